// File: rtl/vwrite_drain_if.sv
// Native databus write port between vwrite_drain (master) and the memory interconnect (slave).
interface vwrite_drain_if #(
  parameter int DATA_W    = 32,
  parameter int IO_ADDR_W = 32
);
  logic                 valid;
  logic                 ready;
  logic [IO_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]    rdata;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W/8-1:0]  wstrb;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/vwrite_drain.sv
// Versat write stage: captures in0 into a two-port buffer under a duty-cycled address pattern
// and drains a contiguous buffer block to external memory. Define VWRITE_DRAIN_PINGPONG_EN to honour pingPong.
//
// engine  | state    | meaning
// capture | CAP_IDLE | nothing to capture
// capture | CAP_WAIT | counting down delayB before the first period
// capture | CAP_RUN  | walking periods, writing in0 during the duty cycles
// drain   | IDLE     | nothing to drain
// drain   | RD       | buffer read issued for the current word
// drain   | REQ      | write request held on the databus until ready
module vwrite_drain #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int IO_ADDR_W  = 32,
  parameter int MEM_ADDR_W = ADDR_W,
  parameter int IO_SIZE_W  = ADDR_W + 1,
  parameter int PERIOD_W   = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  vwrite_drain_if.master        databus,
  input  logic [DATA_W-1:0]     in0,
  input  logic [IO_ADDR_W-1:0]  ext_addr,
  input  logic [MEM_ADDR_W-1:0] int_addr,
  input  logic [IO_SIZE_W-1:0]  size,
  input  logic [MEM_ADDR_W-1:0] iterB,
  input  logic [PERIOD_W-1:0]   perB,
  input  logic [PERIOD_W-1:0]   dutyB,
  input  logic [MEM_ADDR_W-1:0] startB,
  input  logic [MEM_ADDR_W-1:0] incrB,
  input  logic [MEM_ADDR_W-1:0] shiftB,
  input  logic [PERIOD_W-1:0]   delayB,
  input  logic                  pingPong
);

  typedef enum logic [1:0] {CAP_IDLE, CAP_WAIT, CAP_RUN} capState_t;
  typedef enum logic [1:0] {IDLE, RD, REQ} drState_t;

  capState_t capState, capNext;
  drState_t  drState, drNext;

  logic                  accept, ppOn, ppState;
  logic                  capPp, drPp, capDuty, capWe, periodEnd, handshake;
  logic [ADDR_W-1:0]     capStart, drStart, capAddr, capAddrNext, incrR, shiftR, rdAddr;
  logic [PERIOD_W-1:0]   dutyEff, perR, dutyR, perLeft, dutyLeft, delayLeft;
  logic [MEM_ADDR_W-1:0] iterLeft;
  logic [IO_ADDR_W-1:0]  busAddr;
  logic [IO_SIZE_W-1:0]  remaining;
  logic [DATA_W-1:0]     rdData;
  logic [DATA_W-1:0]     mem [2**ADDR_W];
  logic                  unusedBits;

  // In ping-pong mode the MSB selects the half and is never carried into.
  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                             input logic [ADDR_W-1:0] d,
                                             input logic pinMsb);
    logic [ADDR_W-1:0] s;
    s = a + d;
    if (pinMsb) s[ADDR_W-1] = a[ADDR_W-1];
    return s;
  endfunction

`ifdef VWRITE_DRAIN_PINGPONG_EN
  assign ppOn = pingPong;
  always_ff @(posedge clk) begin
    if (rst) ppState <= 1'b0;
    else if (accept) ppState <= pingPong ? ~ppState : 1'b0;
  end
`else
  assign ppOn    = 1'b0;
  assign ppState = 1'b0;
`endif

  assign unusedBits = ^{databus.rdata, pingPong};

  assign done      = (capState == CAP_IDLE) && (drState == IDLE);
  assign accept    = run && done;
  assign capStart  = ppOn ? {ppState, startB[ADDR_W-2:0]} : startB[ADDR_W-1:0];
  assign drStart   = ppOn ? {~ppState, int_addr[ADDR_W-2:0]} : int_addr[ADDR_W-1:0];
  assign dutyEff   = (dutyB > perB) ? perB : dutyB;
  assign capDuty   = (capState == CAP_RUN) && (dutyLeft != '0);
  assign capWe     = capDuty && !rst;
  assign periodEnd = (capState == CAP_RUN) && (perLeft == PERIOD_W'(1));
  assign handshake = (drState == REQ) && databus.ready;
  assign capAddrNext = step(step(capAddr, capDuty ? incrR : '0, capPp),
                            periodEnd ? shiftR : '0, capPp);

  assign databus.valid = (drState == REQ);
  assign databus.wstrb = databus.valid ? '1 : '0;
  assign databus.addr  = busAddr;
  assign databus.wdata = rdData;

  always_comb begin
    capNext = capState;
    drNext  = drState;
    case (capState)
      CAP_IDLE: if (accept && iterB != '0 && perB != '0)
                  capNext = (delayB == '0) ? CAP_RUN : CAP_WAIT;
      CAP_WAIT: if (delayLeft == PERIOD_W'(1)) capNext = CAP_RUN;
      CAP_RUN:  if (periodEnd && iterLeft == MEM_ADDR_W'(1)) capNext = CAP_IDLE;
      default:  capNext = CAP_IDLE;
    endcase
    case (drState)
      IDLE:    if (accept && size != '0) drNext = RD;
      RD:      drNext = REQ;
      REQ:     if (databus.ready) drNext = (remaining == '0) ? IDLE : RD;
      default: drNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      capState <= CAP_IDLE;
      drState  <= IDLE;
      busAddr  <= '0;
      rdData   <= '0;
    end else begin
      capState <= capNext;
      drState  <= drNext;
      if (accept && size != '0) busAddr <= ext_addr;
      else if (handshake && remaining != '0) busAddr <= busAddr + IO_ADDR_W'(DATA_W/8);
      if (drState == RD) rdData <= mem[rdAddr];
    end
  end

  // Run context: only meaningful while the owning engine is busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      capAddr   <= capStart;
      incrR     <= incrB[ADDR_W-1:0];
      shiftR    <= shiftB[ADDR_W-1:0];
      perR      <= perB;
      dutyR     <= dutyEff;
      perLeft   <= perB;
      dutyLeft  <= dutyEff;
      iterLeft  <= iterB;
      delayLeft <= delayB;
      capPp     <= ppOn;
      rdAddr    <= drStart;
      remaining <= size - IO_SIZE_W'(1);
      drPp      <= ppOn;
    end else begin
      if (capState == CAP_WAIT) delayLeft <= delayLeft - PERIOD_W'(1);
      if (capState == CAP_RUN) begin
        capAddr <= capAddrNext;
        if (periodEnd) begin
          perLeft  <= perR;
          dutyLeft <= dutyR;
          iterLeft <= iterLeft - MEM_ADDR_W'(1);
        end else begin
          perLeft <= perLeft - PERIOD_W'(1);
          if (capDuty) dutyLeft <= dutyLeft - PERIOD_W'(1);
        end
      end
      if (handshake && remaining != '0) begin
        rdAddr    <= step(rdAddr, ADDR_W'(1), drPp);
        remaining <= remaining - IO_SIZE_W'(1);
      end
    end
  end

  // Read-first: the drain read sees the value before a same-cycle capture write.
  always_ff @(posedge clk) begin
    if (capWe) mem[capAddr] <= in0;
  end

endmodule

// File: tb/tb_vwrite_drain.sv
// Directed bench for vwrite_drain: capture pattern, drain timing, stalls, ping-pong and reset abort.
`timescale 1ns/1ps
module tb_vwrite_drain;
  localparam int DATA_W = 32, ADDR_W = 10, IO_ADDR_W = 32, IO_SIZE_W = 11, PERIOD_W = 10;
`ifdef VWRITE_DRAIN_PINGPONG_EN
  localparam logic [31:0] EXP_RUN_D = 32'd5;
`else
  localparam logic [31:0] EXP_RUN_D = 32'd7;
`endif

  logic clk = 1'b0;
  logic rst, run, done, pingPong;
  logic [DATA_W-1:0] in0;
  logic [IO_ADDR_W-1:0] ext_addr;
  logic [ADDR_W-1:0] int_addr, iterB, startB, incrB, shiftB;
  logic [IO_SIZE_W-1:0] size;
  logic [PERIOD_W-1:0] perB, dutyB, delayB;
  int checks = 0;
  int errors = 0;
  logic [31:0] gotAddr[$];
  logic [31:0] gotData[$];

  vwrite_drain_if #(.DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W)) bus ();

  vwrite_drain #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_ADDR_W(IO_ADDR_W), .MEM_ADDR_W(ADDR_W),
                 .IO_SIZE_W(IO_SIZE_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .databus(bus), .in0(in0),
    .ext_addr(ext_addr), .int_addr(int_addr), .size(size), .iterB(iterB), .perB(perB),
    .dutyB(dutyB), .startB(startB), .incrB(incrB), .shiftB(shiftB), .delayB(delayB),
    .pingPong(pingPong)
  );

  always #5 clk = ~clk;

  task automatic cfgClear();
    run = 0; pingPong = 0; in0 = '0; ext_addr = '0; int_addr = '0; size = '0;
    iterB = '0; perB = '0; dutyB = '0; startB = '0; incrB = '0; shiftB = '0; delayB = '0;
    bus.ready = 1'b1; bus.rdata = '0;
  endtask

  // Pulses run on the next negedge and records every databus handshake until done returns.
  task automatic pulseAndCollect(output bit timedOut);
    gotAddr.delete(); gotData.delete();
    @(negedge clk); run = 1'b1;
    timedOut = 1'b1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk); run = 1'b0;
      if (bus.valid && bus.ready) begin
        gotAddr.push_back(bus.addr); gotData.push_back(bus.wdata);
      end
      if (done) begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfgClear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b expected 1", done); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h expected 0", bus.wstrb); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.addr); end
    checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.wdata); end
  endtask

  task automatic test_capture();
    cfgClear(); iterB = 1; perB = 4; dutyB = 4; incrB = 1;
    @(negedge clk); run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); run = 1'b0;
      in0 = (k <= 4) ? 32'(10 + k - 1) : 32'h0;
      checks++;
      if (done !== (k == 5)) begin errors++; $display("FAIL capture_done c%0d: got %b expected %b", k, done, (k == 5)); end
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL capture_valid c%0d: got %b expected 0", k, bus.valid); end
    end
  endtask

  task automatic test_drain();
    logic expV;
    int idx;
    cfgClear(); size = 4; ext_addr = 32'h100;
    @(negedge clk); run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); run = 1'b0;
      expV = (k == 2 || k == 4 || k == 6 || k == 8);
      checks++;
      if (bus.valid !== expV) begin errors++; $display("FAIL drain_valid c%0d: got %b expected %b", k, bus.valid, expV); end
      checks++;
      if (done !== (k == 9)) begin errors++; $display("FAIL drain_done c%0d: got %b expected %b", k, done, (k == 9)); end
      if (expV) begin
        idx = (k - 2) / 2;
        checks++;
        if (bus.addr !== 32'(32'h100 + 4 * idx)) begin errors++; $display("FAIL drain_addr c%0d: got %h expected %h", k, bus.addr, 32'h100 + 4 * idx); end
        checks++;
        if (bus.wdata !== 32'(10 + idx)) begin errors++; $display("FAIL drain_wdata c%0d: got %0d expected %0d", k, bus.wdata, 10 + idx); end
        checks++;
        if (bus.wstrb !== 4'hF) begin errors++; $display("FAIL drain_wstrb c%0d: got %h expected f", k, bus.wstrb); end
      end else begin
        checks++;
        if (bus.wstrb !== 4'h0) begin errors++; $display("FAIL drain_wstrb_idle c%0d: got %h expected 0", k, bus.wstrb); end
      end
    end
  endtask

  task automatic test_stall();
    logic expV;
    int hs;
    hs = 0;
    cfgClear(); size = 2; int_addr = 1; ext_addr = 32'h200;
    @(negedge clk); run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); run = 1'b0;
      bus.ready = !(k >= 2 && k <= 4);
      expV = (k >= 2 && k <= 5) || (k == 7);
      checks++;
      if (bus.valid !== expV) begin errors++; $display("FAIL stall_valid c%0d: got %b expected %b", k, bus.valid, expV); end
      if (expV) begin
        checks++;
        if (bus.addr !== ((k == 7) ? 32'h204 : 32'h200)) begin errors++; $display("FAIL stall_addr c%0d: got %h", k, bus.addr); end
        checks++;
        if (bus.wdata !== ((k == 7) ? 32'd12 : 32'd11)) begin errors++; $display("FAIL stall_wdata c%0d: got %0d", k, bus.wdata); end
      end
      if (bus.valid && bus.ready) hs++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
    checks++; if (hs != 2) begin errors++; $display("FAIL stall_handshakes: got %0d expected 2", hs); end
    bus.ready = 1'b1;
  endtask

  task automatic test_pingpong();
    bit to;
    logic [31:0] expect3 [3];
    expect3[0] = 32'd5; expect3[1] = 32'd7; expect3[2] = EXP_RUN_D;
    cfgClear(); pingPong = 1; iterB = 1; perB = 1; dutyB = 1; in0 = 5;
    pulseAndCollect(to);
    checks++; if (to) begin errors++; $display("FAIL pp_runA_timeout: got timeout expected done"); end
    for (int r = 0; r < 3; r++) begin
      cfgClear(); pingPong = 1; size = 1; ext_addr = 32'h40;
      if (r == 0) begin iterB = 1; perB = 1; dutyB = 1; in0 = 7; end
      pulseAndCollect(to);
      checks++;
      if (to || gotData.size() != 1) begin
        errors++; $display("FAIL pp_run%0d_count: got %0d words timeout %b expected 1", r, gotData.size(), to);
      end else begin
        checks++;
        if (gotData[0] !== expect3[r]) begin errors++; $display("FAIL pp_run%0d_data: got %0d expected %0d", r, gotData[0], expect3[r]); end
      end
    end
  endtask

  task automatic test_pattern();
    bit to;
    cfgClear(); startB = 10'h40; perB = 4; dutyB = 2; iterB = 2; incrB = 1; shiftB = 8; delayB = 1;
    @(negedge clk); run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in0 = 32'(100 + k);
      run = (k == 4);
      size = (k == 4) ? 11'd5 : 11'd0;
      checks++;
      if (done !== (k == 10)) begin errors++; $display("FAIL pattern_done c%0d: got %b expected %b", k, done, (k == 10)); end
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL pattern_ignored_run c%0d: valid got %b expected 0", k, bus.valid); end
    end
    cfgClear(); int_addr = 10'h40; size = 12;
    pulseAndCollect(to);
    checks++;
    if (to || gotData.size() != 12) begin
      errors++; $display("FAIL pattern_drain_count: got %0d words timeout %b expected 12", gotData.size(), to);
    end else begin
      checks++; if (gotData[0] !== 32'd102) begin errors++; $display("FAIL pattern_w0: got %0d expected 102", gotData[0]); end
      checks++; if (gotData[1] !== 32'd103) begin errors++; $display("FAIL pattern_w1: got %0d expected 103", gotData[1]); end
      checks++; if (gotData[10] !== 32'd106) begin errors++; $display("FAIL pattern_w10: got %0d expected 106", gotData[10]); end
      checks++; if (gotData[11] !== 32'd107) begin errors++; $display("FAIL pattern_w11: got %0d expected 107", gotData[11]); end
      checks++; if (gotAddr[11] !== 32'h2C) begin errors++; $display("FAIL pattern_a11: got %h expected 2c", gotAddr[11]); end
    end
  endtask

  task automatic test_reset_abort();
    cfgClear(); size = 4; ext_addr = 32'h300;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid: got %b expected 1", bus.valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b expected 1", done); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL abort_addr: got %h expected 0", bus.addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid c%0d: got %b expected 0", k, bus.valid); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_drain();
    test_stall();
    test_pingpong();
    test_pattern();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
